// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and encodings for the instruction-fetch stage.
package ifetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [1:0] {NPC_SEQ = 2'd0, NPC_J = 2'd1, NPC_JR = 2'd2} npc_sel_e;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} if_state_e;
endpackage

// File: rtl/ifetch_npc.sv
// ifetch_npc: control-transfer target calculator and redirect decision from decode.
module ifetch_npc
  import ifetch_pkg::*;
(
  input  logic [1:0]  d_npc_sel_i,
  input  logic        d_pc_mux_sel_i,
  input  logic        d_taken_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_index_i,
  input  logic [31:0] d_jr_tgt_i,
  input  logic [31:0] d_pc4_i,
  input  logic        if_id_valid_i,
  input  logic        stall_i,
  output logic [31:0] target_o,
  output logic        redirect_o
);
  assign target_o = d_npc_sel_i == NPC_J  ? {d_pc4_i[31:28], d_index_i, 2'b00} :
                    d_npc_sel_i == NPC_JR ? (d_jr_tgt_i & ~32'd3) :
                    d_pc4_i + {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};
  // A not-taken branch falls through sequentially and is not a redirect
  assign redirect_o = d_pc_mux_sel_i & if_id_valid_i & ~stall_i &
                      ((d_npc_sel_i != NPC_SEQ) | d_taken_i);
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner, variable-latency instruction fetch and IF/ID register,
// with single-delay-slot redirection from decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 im_req,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic                 im_ready,
  input  logic [31:0]          im_rdata,
  input  logic                 stall,
  input  logic [1:0]           d_npc_sel,
  input  logic                 d_pc_mux_sel,
  input  logic                 d_taken,
  input  logic [15:0]          d_imm16,
  input  logic [25:0]          d_index,
  input  logic [31:0]          d_jr_tgt,
  input  logic [31:0]          d_pc4,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic [31:0]          pc_out
);
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_q, buf_d, tgt_q, tgt_d, instr_q, instr_d, pc4_q, pc4_d;
  logic        pend_q, pend_d, valid_q, valid_d;
  logic [31:0] target, pc_plus4, next_pc;
  logic        redirect, redirect_eff, load, capture;

  ifetch_npc u_npc (
    .d_npc_sel_i    (d_npc_sel),
    .d_pc_mux_sel_i (d_pc_mux_sel),
    .d_taken_i      (d_taken),
    .d_imm16_i      (d_imm16),
    .d_index_i      (d_index),
    .d_jr_tgt_i     (d_jr_tgt),
    .d_pc4_i        (d_pc4),
    .if_id_valid_i  (valid_q),
    .stall_i        (stall),
    .target_o       (target),
    .redirect_o     (redirect)
  );

  assign im_req       = state_q == FETCH;
  assign im_addr      = IM_ADDR_W'((pc_q - RESET_PC) >> 2);
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_eff = redirect & ~pend_q;
  assign capture      = (state_q == FETCH) & im_ready & stall;
  assign load         = ~stall & (((state_q == FETCH) & im_ready) | (state_q == HOLD));
  assign next_pc      = (redirect_eff & load) ? target : pend_q ? tgt_q : pc_plus4;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign pc_out       = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    state_d = state_q == BOOT ? FETCH : capture ? HOLD : (state_q == HOLD && !stall) ? FETCH : state_q;
    buf_d   = capture ? im_rdata : buf_q;
    // A redirect seen while the delay-slot fetch is outstanding waits for that load
    pend_d  = load ? 1'b0 : (redirect_eff | pend_q);
    tgt_d   = (redirect_eff & ~load) ? target : tgt_q;
    if (load) begin
      instr_d = state_q == HOLD ? buf_q : im_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = next_pc;
    end else if (state_q == FETCH && !stall) begin
      instr_d = NOP;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      tgt_q   <= 32'd0;
      pend_q  <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed-vector bench for ifetch_unit with hand-computed expectations.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_req, im_ready = 1'b0, stall = 1'b0;
  logic [9:0]  im_addr;
  logic [31:0] im_rdata;
  logic [1:0]  d_npc_sel = 2'd0;
  logic        d_pc_mux_sel = 1'b0, d_taken = 1'b0;
  logic [15:0] d_imm16 = 16'd0;
  logic [25:0] d_index = 26'd0;
  logic [31:0] d_jr_tgt = 32'd0, d_pc4 = 32'd0;
  logic [31:0] if_id_instr, if_id_pc4, pc_out;
  logic        if_id_valid;
  logic        use_word = 1'b0;
  logic [31:0] word = 32'd0;
  int          n_chk = 0, n_pass = 0;
  localparam logic [31:0] A = 32'hA500_0000;

  // Memory model: each word encodes its own word address unless overridden
  assign im_rdata = use_word ? word : (A | 32'(im_addr));

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr),
    .im_ready(im_ready), .im_rdata(im_rdata), .stall(stall),
    .d_npc_sel(d_npc_sel), .d_pc_mux_sel(d_pc_mux_sel), .d_taken(d_taken),
    .d_imm16(d_imm16), .d_index(d_index), .d_jr_tgt(d_jr_tgt), .d_pc4(d_pc4),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .pc_out(pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                      input logic valid, input logic [31:0] pc);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"}, if_id_pc4, pc4);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    chk({tag, ".pc"}, pc_out, pc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step; step;
    ifid("rst", 32'd0, 32'd0, 1'b0, 32'h3000);
    chk("rst.req", 32'(im_req), 32'd0);
    rst_n = 1'b1;
    chk("boot.req", 32'(im_req), 32'd0);
    step;
    chk("fetch.req", 32'(im_req), 32'd1);
    chk("fetch.addr", 32'(im_addr), 32'd0);
    im_ready = 1'b1;
    step; ifid("seq0", A | 32'd0, 32'h3004, 1'b1, 32'h3004);
    chk("seq0.addr", 32'(im_addr), 32'd1);
    step; ifid("seq1", A | 32'd1, 32'h3008, 1'b1, 32'h3008);
    step; ifid("seq2", A | 32'd2, 32'h300C, 1'b1, 32'h300C);
    im_ready = 1'b0;
    step; ifid("wait0", 32'd0, 32'd0, 1'b0, 32'h300C);
    chk("wait0.addr", 32'(im_addr), 32'd3);
    chk("wait0.req", 32'(im_req), 32'd1);
    step; ifid("wait1", 32'd0, 32'd0, 1'b0, 32'h300C);
    chk("wait1.addr", 32'(im_addr), 32'd3);
    im_ready = 1'b1;
    step; ifid("wait_done", A | 32'd3, 32'h3010, 1'b1, 32'h3010);
    stall = 1'b1; use_word = 1'b1; word = 32'h3C01_1234;
    step; ifid("hold0", A | 32'd3, 32'h3010, 1'b1, 32'h3010);
    chk("hold0.req", 32'(im_req), 32'd0);
    im_ready = 1'b0; use_word = 1'b0;
    step; ifid("hold1", A | 32'd3, 32'h3010, 1'b1, 32'h3010);
    chk("hold1.req", 32'(im_req), 32'd0);
    stall = 1'b0;
    step; ifid("hold_rel", 32'h3C01_1234, 32'h3014, 1'b1, 32'h3014);
    chk("hold_rel.req", 32'(im_req), 32'd1);
    chk("hold_rel.addr", 32'(im_addr), 32'd5);
    im_ready = 1'b1; d_pc_mux_sel = 1'b1; d_npc_sel = 2'd0; d_taken = 1'b1;
    d_pc4 = 32'h3008; d_imm16 = 16'hFFFE;
    step; ifid("beq_slot", A | 32'd5, 32'h3018, 1'b1, 32'h3000);
    chk("beq_slot.addr", 32'(im_addr), 32'd0);
    d_pc_mux_sel = 1'b0;
    step; ifid("beq_tgt", A | 32'd0, 32'h3004, 1'b1, 32'h3004);
    d_pc_mux_sel = 1'b1; d_taken = 1'b0;
    step; ifid("bnt", A | 32'd1, 32'h3008, 1'b1, 32'h3008);
    d_npc_sel = 2'd1; d_index = 26'h000_0C10; d_pc4 = 32'h3010;
    step; ifid("j_slot", A | 32'd2, 32'h300C, 1'b1, 32'h3040);
    chk("j.addr", 32'(im_addr), 32'h10);
    d_npc_sel = 2'd2; d_jr_tgt = 32'h0000_3107;
    step; ifid("jr_slot", A | 32'h10, 32'h3044, 1'b1, 32'h3104);
    chk("jr.addr", 32'(im_addr), 32'h41);
    im_ready = 1'b0; d_npc_sel = 2'd0; d_taken = 1'b1; d_pc4 = 32'h3008; d_imm16 = 16'hFFFE;
    step; ifid("pend_bub", 32'd0, 32'd0, 1'b0, 32'h3104);
    d_npc_sel = 2'd2; d_jr_tgt = 32'h0000_3200;
    step; ifid("pend_ign", 32'd0, 32'd0, 1'b0, 32'h3104);
    chk("pend_ign.addr", 32'(im_addr), 32'h41);
    d_pc_mux_sel = 1'b0; im_ready = 1'b1;
    step; ifid("pend_slot", A | 32'h41, 32'h3108, 1'b1, 32'h3000);
    step; ifid("pend_tgt", A | 32'd0, 32'h3004, 1'b1, 32'h3004);
    im_ready = 1'b0;
    step;
    #3 rst_n = 1'b0;
    #1;
    ifid("arst", 32'd0, 32'd0, 1'b0, 32'h3000);
    chk("arst.req", 32'(im_req), 32'd0);
    chk("arst.addr", 32'(im_addr), 32'd0);
    im_ready = 1'b1;
    step;
    rst_n = 1'b1;
    step; ifid("late_rdy", 32'd0, 32'd0, 1'b0, 32'h3000);
    chk("late_rdy.req", 32'(im_req), 32'd1);
    step; ifid("post_rst", A | 32'd0, 32'h3004, 1'b1, 32'h3004);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
